camera_reg_bank: RTL and testbench

CAMERA_REG_BANK -- requirements
Module: camera_reg_bank

---
 rtl/camera_reg_bank.sv | 180 ++++++++++++++++++
 tb/tb_camera_reg_bank.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_reg_bank.sv
// Camera control register bank: QPI-facing byte register map, exposure timer FSM
// and a small pixel FIFO whose head byte is readable through the map.
module camera_reg_bank #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        main_clock,
  input  logic        rst,
  input  logic [7:0]  addr,
  input  logic [7:0]  write_data,
  input  logic        write_data_flag,
  output logic [7:0]  read_data,
  input  logic        read_data_flag,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic [23:0] exposure,
  output logic [7:0]  gain,
  output logic        exp_active,
  output logic        exp_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [7:0] A_ID      = 8'h00;
  localparam logic [7:0] A_STATUS  = 8'h01;
  localparam logic [7:0] A_CONTROL = 8'h02;
  localparam logic [7:0] A_EXP_LO  = 8'h03;
  localparam logic [7:0] A_EXP_MID = 8'h04;
  localparam logic [7:0] A_EXP_HI  = 8'h05;
  localparam logic [7:0] A_GAIN    = 8'h06;
  localparam logic [7:0] A_LEVEL   = 8'h07;
  localparam logic [7:0] A_PIXEL   = 8'h10;

  typedef enum logic {IDLE, EXPOSE} state_t;

  logic          wr_flag_q, rd_flag_q;
  logic          wr_edge, rd_edge;
  logic          start, abort, clr_ov;
  logic [7:0]    exp_lo, exp_mid, exp_hi, gain_reg;
  state_t        state, state_n;
  logic [23:0]   cnt, cnt_n;
  logic          done_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  logic          full, empty, push, pop, ov_set, overflow;
  logic [7:0]    rd_mux;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge main_clock or posedge rst) begin
    if (rst) begin
      wr_flag_q <= 1'b0;
      rd_flag_q <= 1'b0;
    end else begin
      wr_flag_q <= write_data_flag;
      rd_flag_q <= read_data_flag;
    end
  end

  // A held flag produces exactly one action on its rising edge.
  assign wr_edge = write_data_flag & ~wr_flag_q;
  assign rd_edge = read_data_flag & ~rd_flag_q;

  assign start  = wr_edge && (addr == A_CONTROL) && write_data[0];
  assign abort  = wr_edge && (addr == A_CONTROL) && write_data[1];
  assign clr_ov = wr_edge && (addr == A_CONTROL) && write_data[2];

  always_ff @(posedge main_clock or posedge rst) begin
    if (rst) begin
      exp_lo   <= 8'h00;
      exp_mid  <= 8'h00;
      exp_hi   <= 8'h00;
      gain_reg <= 8'h00;
    end else if (wr_edge) begin
      case (addr)
        A_EXP_LO:  exp_lo   <= write_data;
        A_EXP_MID: exp_mid  <= write_data;
        A_EXP_HI:  exp_hi   <= write_data;
        A_GAIN:    gain_reg <= write_data;
        default: ;
      endcase
    end
  end

  assign exposure = {exp_hi, exp_mid, exp_lo};
  assign gain     = gain_reg;

  always_ff @(posedge main_clock or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 24'd0;
      exp_done <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      exp_done <= done_n;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (exposure != 24'd0) begin
            state_n = EXPOSE;
            cnt_n   = exposure;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      EXPOSE: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 24'd1;
          if (cnt == 24'd1) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign exp_active = (state == EXPOSE);

  assign full   = (fifo_count == DEPTH_CNT);
  assign empty  = (fifo_count == '0);
  assign pop    = rd_edge && (addr == A_PIXEL) && !empty;
  assign push   = pix_valid && (!full || pop);
  assign ov_set = pix_valid && full && !pop;

  // NOTE: the storage array has no reset; stale bytes are unreachable once the pointers clear.
  always_ff @(posedge main_clock) begin
    if (push) mem[wr_ptr] <= pix_data;
  end

  always_ff @(posedge main_clock or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + (AW+1)'(1);
      else if (pop && !push) fifo_count <= fifo_count - (AW+1)'(1);
      if (ov_set)      overflow <= 1'b1;
      else if (clr_ov) overflow <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      A_ID:      rd_mux = 8'hA5;
      A_STATUS:  rd_mux = {4'b0000, overflow, full, empty, exp_active};
      A_EXP_LO:  rd_mux = exp_lo;
      A_EXP_MID: rd_mux = exp_mid;
      A_EXP_HI:  rd_mux = exp_hi;
      A_GAIN:    rd_mux = gain_reg;
      A_LEVEL:   rd_mux = 8'(fifo_count);
      A_PIXEL:   rd_mux = empty ? 8'h00 : mem[rd_ptr];
      default:   rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge main_clock or posedge rst) begin
    if (rst) read_data <= 8'h00;
    else     read_data <= rd_mux;
  end

endmodule

// File: tb/tb_camera_reg_bank.sv
// Scoreboard bench for camera_reg_bank: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_camera_reg_bank;

  logic        main_clock = 1'b0;
  logic        rst;
  logic [7:0]  addr, write_data, read_data, pix_data;
  logic        write_data_flag, read_data_flag, pix_valid;
  logic [23:0] exposure;
  logic [7:0]  gain;
  logic        exp_active, exp_done;

  camera_reg_bank #(.FIFO_DEPTH(16)) dut (
    .main_clock      (main_clock),
    .rst             (rst),
    .addr            (addr),
    .write_data      (write_data),
    .write_data_flag (write_data_flag),
    .read_data       (read_data),
    .read_data_flag  (read_data_flag),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .exposure        (exposure),
    .gain            (gain),
    .exp_active      (exp_active),
    .exp_done        (exp_done)
  );

  always #5 main_clock = ~main_clock;

  int cyc = 0;
  always @(posedge main_clock) cyc <= cyc + 1;

  typedef enum int {S_RD, S_ACT, S_DONE, S_EXPO, S_GAIN, S_ACT_CNT, S_DONE_CNT, S_CLR} sel_t;
  typedef struct {
    int          due;
    sel_t        sel;
    logic [23:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int checks = 0;
  int errors = 0;
  int act_cnt = 0;
  int done_cnt = 0;

  function automatic logic [23:0] observe(sel_t s);
    case (s)
      S_RD:       return {16'h0, read_data};
      S_ACT:      return {23'h0, exp_active};
      S_DONE:     return {23'h0, exp_done};
      S_EXPO:     return exposure;
      S_GAIN:     return {16'h0, gain};
      S_ACT_CNT:  return 24'(act_cnt);
      S_DONE_CNT: return 24'(done_cnt);
      default:    return 24'h0;
    endcase
  endfunction

  // Monitor: accumulate pulse/level counts, then retire every expectation due this cycle.
  always @(negedge main_clock) begin
    chk_t c;
    if (exp_active === 1'b1) act_cnt++;
    if (exp_done === 1'b1) done_cnt++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      c = sb.pop_front();
      if (c.sel == S_CLR) begin
        act_cnt  = 0;
        done_cnt = 0;
      end else begin
        checks++;
        if (c.due != cyc) begin
          errors++;
          $display("FAIL %s: check due at cycle %0d retired late at cycle %0d", c.name, c.due, cyc);
        end else if (observe(c.sel) !== c.exp) begin
          errors++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", c.name, observe(c.sel), c.exp, cyc);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge main_clock);
    #1;
  endtask

  // Queue an expectation for the monitor, d cycles from now, keeping the queue time-ordered.
  task automatic expect_at(input int d, input sel_t s, input logic [23:0] v, input string name);
    chk_t c;
    int i;
    c.due  = cyc + d;
    c.sel  = s;
    c.exp  = v;
    c.name = name;
    i = sb.size();
    while (i > 0 && sb[i-1].due > c.due) i--;
    sb.insert(i, c);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    tick();
    addr = a;
    write_data = d;
    write_data_flag = 1'b1;
    tick();
    write_data_flag = 1'b0;
  endtask

  task automatic rd_pulse();
    tick();
    addr = 8'h10;
    read_data_flag = 1'b1;
    tick();
    read_data_flag = 1'b0;
  endtask

  task automatic show(input logic [7:0] a, input logic [7:0] v, input string name);
    addr = a;
    expect_at(1, S_RD, {16'h0, v}, name);
    tick();
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    addr = 8'h55;
    write_data = 8'h00;
    write_data_flag = 1'b0;
    read_data_flag = 1'b0;
    pix_data = 8'h00;
    pix_valid = 1'b0;

    // Reset state
    tick(3);
    expect_at(0, S_RD,   24'h0, "rst_read_data");
    expect_at(0, S_EXPO, 24'h0, "rst_exposure");
    expect_at(0, S_GAIN, 24'h0, "rst_gain");
    expect_at(0, S_ACT,  24'h0, "rst_exp_active");
    expect_at(0, S_DONE, 24'h0, "rst_exp_done");
    tick();
    rst = 1'b0;
    tick();

    // ID with one-cycle latency, unmapped address
    addr = 8'h00;
    expect_at(0, S_RD, 24'h00, "id_not_yet");
    expect_at(1, S_RD, 24'hA5, "id_read");
    tick();
    show(8'h55, 8'h00, "unmapped_read");
    show(8'h07, 8'h00, "level_after_reset");
    wr(8'h00, 8'h3C);
    show(8'h00, 8'hA5, "id_write_ignored");

    // Five-cycle exposure
    wr(8'h03, 8'h05);
    wr(8'h04, 8'h00);
    wr(8'h05, 8'h00);
    wr(8'h06, 8'h10);
    expect_at(0, S_EXPO, 24'h000005, "exposure_reg");
    expect_at(0, S_GAIN, 24'h10, "gain_reg");
    show(8'h03, 8'h05, "exp_lo_read");
    show(8'h06, 8'h10, "gain_read");
    expect_at(0, S_CLR, 24'h0, "clr");
    wr(8'h02, 8'h01);
    expect_at(0, S_ACT,  24'h1, "act_first_cycle");
    expect_at(4, S_ACT,  24'h1, "act_fifth_cycle");
    expect_at(5, S_ACT,  24'h0, "act_falls");
    expect_at(5, S_DONE, 24'h1, "done_pulse");
    expect_at(6, S_DONE, 24'h0, "done_one_cycle");
    show(8'h01, 8'h03, "status_active_empty");
    show(8'h02, 8'h00, "control_reads_zero");
    tick(10);
    expect_at(0, S_ACT_CNT,  24'd5, "act_len_5");
    expect_at(0, S_DONE_CNT, 24'd1, "done_count_5");

    // Abort a 256-cycle exposure after it has run a while
    wr(8'h03, 8'h00);
    wr(8'h04, 8'h01);
    expect_at(0, S_CLR, 24'h0, "clr");
    wr(8'h02, 8'h01);
    expect_at(10, S_ACT, 24'h1, "abort_pre");
    expect_at(11, S_ACT, 24'h0, "abort_fall");
    tick(9);
    wr(8'h02, 8'h02);
    tick(300);
    expect_at(0, S_ACT_CNT,  24'd11, "abort_act_len");
    expect_at(0, S_DONE_CNT, 24'd0,  "abort_no_done");

    // Zero exposure: done only
    wr(8'h04, 8'h00);
    expect_at(0, S_CLR, 24'h0, "clr");
    wr(8'h02, 8'h01);
    expect_at(0, S_DONE, 24'h1, "zero_done");
    expect_at(0, S_ACT,  24'h0, "zero_no_active");
    expect_at(1, S_DONE, 24'h0, "zero_done_once");
    tick(5);
    expect_at(0, S_ACT_CNT,  24'd0, "zero_act_len");
    expect_at(0, S_DONE_CNT, 24'd1, "zero_done_count");

    // FIFO read-out
    tick();
    pix_data = 8'h11;
    pix_valid = 1'b1;
    tick();
    pix_data = 8'h22;
    tick();
    pix_valid = 1'b0;
    show(8'h07, 8'h02, "level_2");
    show(8'h10, 8'h11, "pix_head_11");
    rd_pulse();
    expect_at(1, S_RD, 24'h22, "pix_head_22");
    tick();
    show(8'h07, 8'h01, "level_1");
    rd_pulse();
    expect_at(1, S_RD, 24'h00, "pix_empty");
    tick();
    show(8'h07, 8'h00, "level_0");
    rd_pulse();
    expect_at(1, S_RD, 24'h00, "pix_empty_again");
    tick();
    show(8'h07, 8'h00, "level_stays_0");
    show(8'h01, 8'h02, "status_empty");

    // Fill past full, clear overflow, push+pop at full
    tick();
    pix_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      pix_data = 8'(i);
      tick();
    end
    pix_valid = 1'b0;
    show(8'h07, 8'h10, "level_full");
    show(8'h01, 8'h0C, "status_overflow_full");
    show(8'h10, 8'h01, "head_after_fill");
    wr(8'h02, 8'h04);
    show(8'h01, 8'h04, "status_ov_cleared");
    addr = 8'h10;
    read_data_flag = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'h99;
    tick();
    read_data_flag = 1'b0;
    pix_valid = 1'b0;
    expect_at(1, S_RD, 24'h02, "head_after_pushpop");
    tick();
    show(8'h01, 8'h04, "status_no_ov_pushpop");
    show(8'h07, 8'h10, "level_still_full");

    // Held write flag starts exactly one exposure
    wr(8'h03, 8'h08);
    expect_at(0, S_CLR, 24'h0, "clr");
    tick();
    addr = 8'h02;
    write_data = 8'h01;
    write_data_flag = 1'b1;
    tick(20);
    write_data_flag = 1'b0;
    tick(20);
    expect_at(0, S_ACT_CNT,  24'd8, "held_act_len");
    expect_at(0, S_DONE_CNT, 24'd1, "held_done_count");

    // Reset in the middle of an exposure
    wr(8'h03, 8'h40);
    expect_at(0, S_CLR, 24'h0, "clr");
    wr(8'h02, 8'h01);
    addr = 8'h00;
    tick(5);
    rst = 1'b1;
    expect_at(0, S_ACT,  24'h0, "midrst_active");
    expect_at(0, S_DONE, 24'h0, "midrst_done");
    expect_at(0, S_EXPO, 24'h0, "midrst_exposure");
    expect_at(0, S_GAIN, 24'h0, "midrst_gain");
    expect_at(0, S_RD,   24'h0, "midrst_read_data");
    tick(2);
    rst = 1'b0;
    show(8'h07, 8'h00, "level_after_midrst");
    show(8'h01, 8'h02, "status_after_midrst");
    tick(80);
    expect_at(0, S_ACT_CNT,  24'd5, "midrst_act_len");
    expect_at(0, S_DONE_CNT, 24'd0, "midrst_no_done");

    guard = 0;
    while (sb.size() > 0 && guard < 1000) begin
      tick();
      guard++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations still pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
